// File: rtl/spi_cmd_deserializer_if.sv
// spi_cmd_deserializer_if: SPI pad bundle between an SPI master and the command deserializer.
interface spi_cmd_deserializer_if;
    logic spi_sclk_in;
    logic spi_cs_n_in;
    logic spi_mosi_in;
    logic spi_miso_out;
    logic spi_miso_oeb;
    modport master(output spi_sclk_in, spi_cs_n_in, spi_mosi_in, input spi_miso_out, spi_miso_oeb);
    modport slave(input spi_sclk_in, spi_cs_n_in, spi_mosi_in, output spi_miso_out, spi_miso_oeb);
endinterface

// File: rtl/spi_cmd_deserializer.sv
// spi_cmd_deserializer: oversampled SPI mode-0 slave that publishes each 32-bit frame with a stretched strobe.
module spi_cmd_deserializer #(
    parameter int WORD_WIDTH    = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int STROBE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    spi_cmd_deserializer_if.slave spi,
    input  logic [WORD_WIDTH-1:0] status_word,
    output logic [WORD_WIDTH-1:0] spi_data,
    output logic                  spi_data_clock,
    output logic                  frame_error,
    output logic                  overrun
);
    localparam int CNT_W = $clog2(WORD_WIDTH) + 1;
    localparam int PC_W  = $clog2(STROBE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(WORD_WIDTH - 1);
    localparam logic [PC_W-1:0]  PLAST   = PC_W'(STROBE_CYCLES - 1);
    typedef enum logic [1:0] {R_IDLE, R_SHIFT, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_SETUP, P_HIGH, P_LOW} pub_state_t;
    // sclk/cs carry one extra stage past the synchronizer for edge detection
    logic [SYNC_STAGES:0]   sclk_q, sclk_d, cs_q, cs_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    rx_state_t              rx_q, rx_d;
    pub_state_t             pub_q, pub_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [PC_W-1:0]        pub_cnt_q, pub_cnt_d;
    logic [WORD_WIDTH-1:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, data_q, data_d;
    logic                   miso_q, miso_d, oeb_q, oeb_d, bad_q, bad_d;
    logic                   dclk_q, dclk_d, frame_error_q, frame_error_d, overrun_q, overrun_d;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s, word_rdy;
    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
    assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
    assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    always_comb begin
        sclk_d        = {sclk_q[SYNC_STAGES-1:0], spi.spi_sclk_in};
        cs_d          = {cs_q[SYNC_STAGES-1:0], spi.spi_cs_n_in};
        mosi_d        = {mosi_q[SYNC_STAGES-2:0], spi.spi_mosi_in};
        rx_d          = rx_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        miso_d        = miso_q;
        oeb_d         = oeb_q;
        bad_d         = bad_q;
        frame_error_d = 1'b0;
        word_rdy      = 1'b0;
        case (rx_q)
            R_IDLE: if (cs_fall) begin
                bit_cnt_d  = '0;
                bad_d      = 1'b0;
                tx_shift_d = status_word;
                miso_d     = status_word[WORD_WIDTH-1];
                oeb_d      = 1'b0;
                rx_d       = R_SHIFT;
            end
            R_SHIFT: if (cs_rise) begin
                frame_error_d = 1'b1;
                miso_d        = 1'b0;
                oeb_d         = 1'b1;
                rx_d          = R_IDLE;
            end else if (sclk_rise) begin
                rx_shift_d = {rx_shift_q[WORD_WIDTH-2:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_M1) begin
                    miso_d = 1'b0;
                    rx_d   = R_WAIT;
                end
            end else if (sclk_fall && bit_cnt_q != '0) begin
                tx_shift_d = tx_shift_q << 1;
                miso_d     = tx_shift_q[WORD_WIDTH-2];
            end
            R_WAIT: if (cs_rise) begin
                word_rdy      = ~bad_q;
                frame_error_d = bad_q;
                oeb_d         = 1'b1;
                rx_d          = R_IDLE;
            end else if (sclk_rise) begin
                bad_d = 1'b1;
            end
            default: rx_d = R_IDLE;
        endcase
        pub_d     = pub_q;
        pub_cnt_d = pub_cnt_q;
        data_d    = data_q;
        dclk_d    = dclk_q;
        overrun_d = word_rdy && pub_q != P_IDLE;
        case (pub_q)
            P_IDLE: if (word_rdy) begin
                data_d = rx_shift_q;
                pub_d  = P_SETUP;
            end
            P_SETUP: begin
                dclk_d    = 1'b1;
                pub_cnt_d = '0;
                pub_d     = P_HIGH;
            end
            P_HIGH: if (pub_cnt_q == PLAST) begin
                dclk_d    = 1'b0;
                pub_cnt_d = '0;
                pub_d     = P_LOW;
            end else begin
                pub_cnt_d = pub_cnt_q + 1'b1;
            end
            P_LOW: if (pub_cnt_q == PLAST) pub_d = P_IDLE;
                   else pub_cnt_d = pub_cnt_q + 1'b1;
            default: pub_d = P_IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q        <= '0;
            cs_q          <= '1;
            mosi_q        <= '0;
            rx_q          <= R_IDLE;
            pub_q         <= P_IDLE;
            bit_cnt_q     <= '0;
            pub_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            data_q        <= '0;
            miso_q        <= 1'b0;
            oeb_q         <= 1'b1;
            bad_q         <= 1'b0;
            dclk_q        <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sclk_q        <= sclk_d;
            cs_q          <= cs_d;
            mosi_q        <= mosi_d;
            rx_q          <= rx_d;
            pub_q         <= pub_d;
            bit_cnt_q     <= bit_cnt_d;
            pub_cnt_q     <= pub_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            data_q        <= data_d;
            miso_q        <= miso_d;
            oeb_q         <= oeb_d;
            bad_q         <= bad_d;
            dclk_q        <= dclk_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end
    assign spi.spi_miso_out = miso_q;
    assign spi.spi_miso_oeb = oeb_q;
    assign spi_data         = data_q;
    assign spi_data_clock   = dclk_q;
    assign frame_error      = frame_error_q;
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_spi_cmd_deserializer.sv
// tb_spi_cmd_deserializer: directed SPI frames with hand-computed expected words, strobe timing and error pulses.
module tb_spi_cmd_deserializer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] status_word = 32'hDEADBEEF;
    logic [31:0] spi_data;
    logic        spi_data_clock, frame_error, overrun;
    int          n_err = 0, n_chk = 0;
    int          fe_n = 0, ov_n = 0, rise_n = 0, hi_run = 0, lo_run = 0, last_hi = 0, last_lo = 0;
    logic        dclk_p = 1'b0;
    logic [31:0] data_p = '0, pre_data = '0;
    spi_cmd_deserializer_if bus();
    spi_cmd_deserializer dut (
        .clock(clock), .reset_n(reset_n), .spi(bus.slave), .status_word(status_word),
        .spi_data(spi_data), .spi_data_clock(spi_data_clock), .frame_error(frame_error), .overrun(overrun)
    );
    always #5 clock = ~clock;
    // pulse counters and strobe high/low run lengths, sampled on pre-edge values
    always @(posedge clock) begin
        dclk_p <= spi_data_clock;
        data_p <= spi_data;
        if (frame_error) fe_n <= fe_n + 1;
        if (overrun) ov_n <= ov_n + 1;
        if (spi_data_clock) hi_run <= hi_run + 1;
        else lo_run <= lo_run + 1;
        if (spi_data_clock && !dclk_p) begin
            rise_n   <= rise_n + 1;
            pre_data <= data_p;
            last_lo  <= lo_run;
            lo_run   <= 0;
        end
        if (!spi_data_clock && dclk_p) begin
            last_hi <= hi_run;
            hi_run  <= 0;
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask
    task automatic spi_bit(input logic b, output logic m);
        bus.spi_mosi_in = b;
        cyc(2);
        bus.spi_sclk_in = 1'b1;
        cyc(2);
        m = bus.spi_miso_out;
        bus.spi_sclk_in = 1'b0;
    endtask
    task automatic frame(input logic [31:0] w, input int n, output logic [31:0] m);
        logic b;
        bus.spi_cs_n_in = 1'b0;
        cyc(6);
        m = '0;
        for (int i = 0; i < n; i++) begin
            spi_bit(i < 32 ? w[31-i] : 1'b0, b);
            m = {m[30:0], b};
        end
        cyc(2);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        logic [31:0] m;
        logic        b;
        int fe0, ov0, r0;
        bus.spi_sclk_in = 1'b0;
        bus.spi_cs_n_in = 1'b1;
        bus.spi_mosi_in = 1'b0;
        cyc(3);
        chk("rst_data", spi_data, 32'h0);
        chk("rst_outs", {spi_data_clock, frame_error, overrun, bus.spi_miso_out, bus.spi_miso_oeb}, 32'h1);
        reset_n = 1'b1;
        cyc(3);
        frame(32'hA5C30F01, 32, m);
        chk("miso_word", m, 32'hDEADBEEF);
        chk("wait_pins", {bus.spi_miso_out, bus.spi_miso_oeb}, 32'h0);
        bus.spi_cs_n_in = 1'b1;
        cyc(3);
        chk("lat_data", spi_data, 32'hA5C30F01);
        chk("lat_strobe_lo", spi_data_clock, 1'b0);
        cyc(1);
        chk("lat_strobe_hi", spi_data_clock, 1'b1);
        cyc(12);
        chk("pre_data", pre_data, 32'hA5C30F01);
        chk("high_len", last_hi, 4);
        chk("oeb_idle", bus.spi_miso_oeb, 1'b1);
        bus.spi_cs_n_in = 1'b0;
        cyc(6);
        for (int i = 0; i < 10; i++) spi_bit(1'b1, b);
        chk("oeb_mid", bus.spi_miso_oeb, 1'b0);
        reset_n = 1'b0;
        #2;
        chk("async_data", spi_data, 32'h0);
        chk("async_outs", {spi_data_clock, frame_error, overrun, bus.spi_miso_out, bus.spi_miso_oeb}, 32'h1);
        bus.spi_cs_n_in = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        frame(32'h12345678, 32, m);
        bus.spi_cs_n_in = 1'b1;
        cyc(4);
        chk("post_rst_data", spi_data, 32'h12345678);
        cyc(12);
        fe0 = fe_n;
        r0 = rise_n;
        frame(32'hCAFEF00D, 31, m);
        bus.spi_cs_n_in = 1'b1;
        cyc(8);
        chk("short_fe", fe_n - fe0, 1);
        frame(32'hCAFEF00D, 33, m);
        bus.spi_cs_n_in = 1'b1;
        cyc(8);
        chk("long_fe", fe_n - fe0, 2);
        chk("err_no_strobe", rise_n - r0, 0);
        chk("err_data", spi_data, 32'h12345678);
        bus.spi_cs_n_in = 1'b0;
        cyc(6);
        chk("toggle_oeb_lo", bus.spi_miso_oeb, 1'b0);
        bus.spi_cs_n_in = 1'b1;
        cyc(6);
        chk("toggle_oeb_hi", bus.spi_miso_oeb, 1'b1);
        chk("toggle_fe", fe_n - fe0, 3);
        ov0 = ov_n;
        r0 = rise_n;
        frame(32'h00000001, 32, m);
        bus.spi_cs_n_in = 1'b1;
        for (int i = 0; i < 12 && !spi_data_clock; i++) cyc(1);
        chk("ovr_strobe", spi_data_clock, 1'b1);
        force dut.pub_cnt_q = '0;
        frame(32'hFFFFFFFF, 32, m);
        bus.spi_cs_n_in = 1'b1;
        cyc(8);
        chk("ovr_pulse", ov_n - ov0, 1);
        chk("ovr_data", spi_data, 32'h00000001);
        release dut.pub_cnt_q;
        cyc(20);
        chk("ovr_one_strobe", rise_n - r0, 1);
        chk("ovr_strobe_end", spi_data_clock, 1'b0);
        r0 = rise_n;
        frame(32'h00000000, 32, m);
        bus.spi_cs_n_in = 1'b1;
        cyc(4);
        chk("b2b_data0", spi_data, 32'h0);
        frame(32'h80000000, 32, m);
        bus.spi_cs_n_in = 1'b1;
        cyc(4);
        chk("b2b_data1", spi_data, 32'h80000000);
        cyc(12);
        chk("b2b_strobes", rise_n - r0, 2);
        chk("b2b_high", last_hi, 4);
        chk("b2b_low_min", last_lo >= 4, 1'b1);
        chk("b2b_pre_data", pre_data, 32'h80000000);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
